alu_seq: RTL and testbench

Parametrised, handshaked successor to the CPU's 8-bit accumulator ALU. It accepts one operation per request, covering the original 3-bit instruction set plus SUB, OR, shifts and an optional multi-cycle multiply. It returns a registered result with zero/carry/negative flags and a one-cycle completion strobe. It sits between the controller/decoder and the accumulator register. `acc_zero` preserves the combinational SKZ test.

---
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked accumulator ALU with registered result/flags and an optional
// shift-add multiply that occupies the block for WIDTH cycles.
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] accum,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             zero,
   output logic             carry,
   output logic             neg,
   output logic             acc_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_LDA = 4'd5;
   localparam logic [3:0] OP_SUB = 4'd8;
   localparam logic [3:0] OP_OR  = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;
   localparam logic [3:0] OP_SHR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               neg_q, neg_d;
   logic               valid_q, valid_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [WIDTH-1:0]   res_c;
   logic               cy_c;
   logic [2*WIDTH-1:0] prod_nx;
   logic               accept;
   logic               is_mul;
   logic               done;

   assign acc_zero  = (accum == '0);
   assign out       = out_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign neg       = neg_q;
   assign out_valid = valid_q;

   assign accept  = in_valid && in_ready;
   assign is_mul  = MUL_EN && (opcode == OP_MUL);
   assign done    = (state_q == S_MUL) && (cnt_q == CW'(1));
   assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);

   // Single-cycle result; unlisted opcodes (and MUL when disabled) pass A.
   always_comb begin
      res_c = accum;
      cy_c  = 1'b0;
      case (opcode)
         OP_ADD: {cy_c, res_c} = {1'b0, accum} + {1'b0, data};
         OP_AND: res_c = accum & data;
         OP_XOR: res_c = accum ^ data;
         OP_LDA: res_c = data;
         OP_SUB: {cy_c, res_c} = {1'b0, accum} - {1'b0, data};
         OP_OR:  res_c = accum | data;
         OP_SHL: begin
            res_c = accum << 1;
            cy_c  = accum[WIDTH-1];
         end
         OP_SHR: begin
            res_c = accum >> 1;
            cy_c  = accum[0];
         end
         default: res_c = accum;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept && is_mul) state_d = S_MUL;
         S_MUL:  if (done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_IDLE);
      busy     = (state_q == S_MUL);
   end

   always_comb begin
      out_d    = out_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      neg_d    = neg_q;
      valid_d  = 1'b0;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (accept) begin
         if (is_mul) begin
            mcand_d  = {{WIDTH{1'b0}}, accum};
            mplier_d = data;
            prod_d   = '0;
            cnt_d    = CW'(WIDTH);
         end else begin
            out_d   = res_c;
            zero_d  = (res_c == '0);
            carry_d = cy_c;
            neg_d   = res_c[WIDTH-1];
            valid_d = 1'b1;
         end
      end else if (state_q == S_MUL) begin
         prod_d   = prod_nx;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         // Last iteration: the final partial add feeds the result directly.
         if (done) begin
            out_d   = prod_nx[WIDTH-1:0];
            zero_d  = (prod_nx[WIDTH-1:0] == '0);
            carry_d = |prod_nx[2*WIDTH-1:WIDTH];
            neg_d   = prod_nx[WIDTH-1];
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q    <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         neg_q    <= 1'b0;
         valid_q  <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         out_q    <= out_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         neg_q    <= neg_d;
         valid_q  <= valid_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one instance with multiply, one without.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] opcode = 4'd0;
   logic [7:0] accum = 8'd0;
   logic [7:0] data = 8'd0;

   logic       in_ready, out_valid, zero, carry, neg, acc_zero, busy;
   logic [7:0] out;
   logic       in_ready0, out_valid0, zero0, carry0, neg0, acc_zero0, busy0;
   logic [7:0] out0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .accum(accum), .data(data), .out(out),
      .out_valid(out_valid), .zero(zero), .carry(carry), .neg(neg),
      .acc_zero(acc_zero), .busy(busy)
   );

   alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .opcode(opcode), .accum(accum), .data(data), .out(out0),
      .out_valid(out_valid0), .zero(zero0), .carry(carry0), .neg(neg0),
      .acc_zero(acc_zero0), .busy(busy0)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic go(input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] d);
      @(negedge clk);
      opcode = op;
      accum = a;
      data = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   logic [3:0] pt_ops [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd15};
   int lat;
   int seen;

   initial begin
      // async reset before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_out", out, 8'h00);
      chk("rst_flags", {zero, carry, neg}, 3'b000);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_ready", in_ready, 1'b1);

      go(4'd2, 8'hF0, 8'h20);
      chk("add_out", out, 8'h10);
      chk("add_zcn", {zero, carry, neg}, 3'b010);
      chk("add_vld", out_valid, 1'b1);
      @(posedge clk);
      #1 chk("add_pulse", out_valid, 1'b0);

      // async reset mid-cycle clears a live result
      go(4'd5, 8'h00, 8'h77);
      chk("lda_vld", {out_valid, out}, {1'b1, 8'h77});
      #2 rst = 1'b1;
      #1;
      chk("arst_out", {out_valid, out}, 9'h000);
      @(negedge clk);
      rst = 1'b0;

      go(4'd8, 8'h05, 8'h05);
      chk("sub_eq", {out, zero, carry, neg}, {8'h00, 3'b100});
      go(4'd8, 8'h03, 8'h05);
      chk("sub_lt", {out, zero, carry, neg}, {8'hFE, 3'b011});
      go(4'd10, 8'h81, 8'h00);
      chk("shl", {out, carry}, {8'h02, 1'b1});
      go(4'd11, 8'h81, 8'h00);
      chk("shr", {out, carry}, {8'h40, 1'b1});

      // back-to-back AND, XOR, OR
      @(negedge clk);
      accum = 8'hCC;
      data = 8'hAA;
      opcode = 4'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1 chk("b2b_and", {out_valid, out}, {1'b1, 8'h88});
      opcode = 4'd4;
      @(posedge clk);
      #1 chk("b2b_xor", {out_valid, out}, {1'b1, 8'h66});
      opcode = 4'd9;
      @(posedge clk);
      #1 chk("b2b_or", {out_valid, out, neg}, {1'b1, 8'hEE, 1'b1});
      in_valid = 1'b0;
      @(posedge clk);
      #1 chk("b2b_end", out_valid, 1'b0);

      // multiply with a request held while busy
      @(negedge clk);
      opcode = 4'd12;
      accum = 8'h12;
      data = 8'h34;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("mul_rdy", {in_ready, busy}, 2'b01);
      opcode = 4'd2;
      accum = 8'h01;
      data = 8'h01;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      chk("mul_lat", lat, 8);
      chk("mul_out", {out, zero, carry, neg}, {8'hA8, 3'b011});
      chk("mul_idle", {in_ready, busy}, 2'b10);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("held_add", {out_valid, out}, {1'b1, 8'h02});

      // reset mid-multiply
      @(negedge clk);
      opcode = 4'd12;
      accum = 8'hFF;
      data = 8'hFF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("mr_busy", busy, 1'b1);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mr_state", {out, in_ready, busy, out_valid}, {8'h00, 3'b100});
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      chk("mr_novld", seen, 0);
      chk("mr_out", out, 8'h00);
      go(4'd2, 8'h01, 8'h02);
      chk("mr_add", {out_valid, out, carry}, {1'b1, 8'h03, 1'b0});

      foreach (pt_ops[i]) begin
         go(pt_ops[i], 8'h00, 8'h5A);
         chk($sformatf("pt_%0d", pt_ops[i]), {out, zero, carry},
             {8'h00, 2'b10});
      end

      // acc_zero is combinational
      @(negedge clk);
      accum = 8'h00;
      #1 chk("az_0", acc_zero, 1'b1);
      accum = 8'h04;
      #1 chk("az_4", acc_zero, 1'b0);
      accum = 8'h00;
      #1 chk("az_back", acc_zero, 1'b1);

      go(4'd12, 8'h37, 8'h10);
      chk("nomul_out", {out_valid0, out0, carry0}, {1'b1, 8'h37, 1'b0});
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      chk("mul2_lat", lat, 8);
      chk("mul2_out", {out, carry}, {8'h70, 1'b1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
